// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared defaults and FSM state type for the serializer arbiter
package ser_pkg;
  localparam int SER_NREQ  = 4;
  localparam int SER_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } ser_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr_i
// With SER_ARB_PRIO0_EN defined, requester 0 overrides the rotating order.
module rr_arbiter import ser_pkg::*; #(
  parameter int  NREQ = SER_NREQ,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o
);
  logic          found;
  logic [PW-1:0] sel;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    sel     = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel = PW'((int'(ptr_i) + i) % NREQ);
      if (!found && req_i[sel]) begin
        grant_o[sel] = 1'b1;
        found        = 1'b1;
      end
    end
`ifdef SER_ARB_PRIO0_EN
    // the rotating search above still orders requesters 1..NREQ-1 fairly
    if (req_i[0]) begin
      grant_o    = '0;
      grant_o[0] = 1'b1;
    end
`endif
  end
endmodule

// File: rtl/ser_arbiter.sv
// rtl/ser_arbiter.sv - shares one serializer among NREQ requesters (IDLE/LOAD/SEND/DONE)
// Build with SER_ARB_PRIO0_EN to give requester 0 absolute priority in rr_arbiter.
module ser_arbiter import ser_pkg::*; #(
  parameter int  NREQ  = SER_NREQ,
  parameter int  WIDTH = SER_WIDTH,
  localparam int PW    = $clog2(NREQ),
  localparam int BW    = $clog2(WIDTH)
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       done,
  output logic                  ser_load,
  output logic [WIDTH-1:0]      ser_data,
  output logic                  ser_send,
  output logic [BW-1:0]         bit_idx,
  output logic                  busy
);
  ser_state_e       state_q;
  logic [PW-1:0]    ptr_q, win_q, win_d;
  logic [WIDTH-1:0] data_q, word_d;
  logic [BW-1:0]    cnt_q;
  logic [NREQ-1:0]  grant, ack_q, done_q;
  logic             load_q, send_q;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    win_d  = '0;
    word_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_d  = PW'(i);
        word_d = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // data_q doubles as the latched word: captured once in IDLE, cleared after LOAD
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      load_q  <= 1'b0;
      send_q  <= 1'b0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      load_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            win_q   <= win_d;
            data_q  <= word_d;
            ack_q   <= grant;
            load_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          data_q  <= '0;
          send_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (cnt_q == BW'(WIDTH - 1)) begin
            send_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= NREQ'(1) << win_q;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          ptr_q   <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign ser_load = load_q;
  assign ser_data = data_q;
  assign ser_send = send_q;
  assign bit_idx  = cnt_q;
  assign busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ser_arbiter.sv
// tb/tb_ser_arbiter.sv - directed scoreboard bench for ser_arbiter
module tb_ser_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 12;

  typedef struct {
    int          idx;
    logic [11:0] word;
  } exp_t;

  logic        CLK = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [47:0] data_in;
  logic [3:0]  ack, done;
  logic        ser_load, ser_send, busy;
  logic [11:0] ser_data;
  logic [3:0]  bit_idx;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_load = 0, n_done = 0, nsend = 0;
  int   load_cyc = 0, first_send_cyc = 0, done_cyc = 0;
  bit   gap_chk = 1'b0;
  exp_t sbq[$];
  exp_t cur;

  ser_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK      (CLK),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .done     (done),
    .ser_load (ser_load),
    .ser_data (ser_data),
    .ser_send (ser_send),
    .bit_idx  (bit_idx),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: pops an expected grant on every serializer load
  always @(negedge CLK) begin
    if (rst) begin
      nsend = 0;
    end else begin
      if (ser_load) begin
        n_load++;
        load_cyc = cyc;
        if (sbq.size() == 0) begin
          chk("unexpected_load", 32'd1, 32'd0);
        end else begin
          cur = sbq.pop_front();
          chk("ack_grant", 32'(ack), 32'(1) << cur.idx);
          chk("ser_data", 32'(ser_data), 32'(cur.word));
          if (gap_chk) chk("done_to_ack_gap", cyc - done_cyc, 32'd2);
        end
        nsend = 0;
      end else begin
        chk("ack_idle", 32'(ack), 32'd0);
        chk("ser_data_idle", 32'(ser_data), 32'd0);
      end
      if (ser_send) begin
        if (nsend == 0) first_send_cyc = cyc;
        chk("bit_idx", 32'(bit_idx), nsend);
        nsend++;
      end else begin
        chk("bit_idx_idle", 32'(bit_idx), 32'd0);
      end
      if (done != 4'b0) begin
        n_done++;
        done_cyc = cyc;
        chk("done_grant", 32'(done), 32'(1) << cur.idx);
        chk("bits_sent", nsend, WIDTH);
      end
      chk("busy", 32'(busy), 32'(ser_load || ser_send || (done != 4'b0)));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_req(input logic [3:0] r);
    req = r;
    @(posedge CLK);
    #1;
    req = '0;
  endtask

  task automatic wait_loads(input int n, input string tag);
    int k;
    k = 0;
    while (n_load < n && k < 200) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk(tag, 32'(n_load >= n), 32'd1);
  endtask

  task automatic wait_dones(input int n, input string tag);
    int k;
    k = 0;
    while (n_done < n && k < 200) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk(tag, 32'(n_done >= n), 32'd1);
  endtask

  initial begin
    int base, nd, k;
    rst     = 1'b1;
    req     = '0;
    data_in = '0;

    // reset state
    do_reset();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_load", 32'(ser_load), 32'd0);
    chk("rst_data", 32'(ser_data), 32'd0);
    chk("rst_send", 32'(ser_send), 32'd0);
    chk("rst_bit_idx", 32'(bit_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // single transfer, latency relative to sampling cycle
    data_in[0 +: 12] = 12'hA5C;
    sbq.push_back('{0, 12'hA5C});
    base = cyc;
    nd   = n_done;
    pulse_req(4'b0001);
    wait_dones(nd + 1, "t1_timeout");
    chk("t1_load_cyc", load_cyc, base + 1);
    chk("t1_first_send", first_send_cyc, base + 2);
    chk("t1_done_cyc", done_cyc, base + 14);

    // all requesting: round-robin 0,1,2,3,0
    do_reset();
    data_in = {12'h333, 12'h222, 12'h111, 12'h0F0};
    sbq.push_back('{0, 12'h0F0});
    sbq.push_back('{1, 12'h111});
    sbq.push_back('{2, 12'h222});
    sbq.push_back('{3, 12'h333});
    sbq.push_back('{0, 12'h0F0});
    nd  = n_done;
    k   = n_load;
    req = 4'b1111;
    wait_dones(nd + 1, "t2_first_timeout");
    gap_chk = 1'b1;
    wait_loads(k + 5, "t2_load_timeout");
    req = '0;
    wait_dones(nd + 5, "t2_done_timeout");
    gap_chk = 1'b0;

    // captured word immune to data_in change during LOAD
    data_in[24 +: 12] = 12'h3C5;
    sbq.push_back('{2, 12'h3C5});
    nd  = n_done;
    req = 4'b0100;
    @(posedge CLK);
    #1;
    req     = '0;
    data_in = '1;
    wait_dones(nd + 1, "t3_timeout");

    // reset mid-transfer at bit_idx 5
    data_in[0 +: 12] = 12'h123;
    sbq.push_back('{0, 12'h123});
    pulse_req(4'b0001);
    k = 0;
    while (!(ser_send && bit_idx == 4'd5) && k < 100) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk("t4_reach_bit5", 32'(ser_send && bit_idx == 4'd5), 32'd1);
    nd  = n_done;
    rst = 1'b1;
    @(posedge CLK);
    #1;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_send", 32'(ser_send), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    chk("t4_no_done", n_done, nd);
    data_in[12 +: 12] = 12'h456;
    sbq.push_back('{1, 12'h456});
    pulse_req(4'b0010);
    wait_dones(nd + 1, "t4_after_timeout");

`ifdef SER_ARB_PRIO0_EN
    // requester 0 pre-empts the rotation once it asks
    do_reset();
    data_in = {12'hD03, 12'hC02, 12'hB01, 12'hA00};
    sbq.push_back('{1, 12'hB01});
    sbq.push_back('{0, 12'hA00});
    sbq.push_back('{2, 12'hC02});
    nd  = n_done;
    k   = n_load;
    req = 4'b1110;
    wait_loads(k + 1, "t5_l1_timeout");
    req = 4'b1101;
    wait_loads(k + 2, "t5_l2_timeout");
    req = 4'b1100;
    wait_loads(k + 3, "t5_l3_timeout");
    req = '0;
    wait_dones(nd + 3, "t5_done_timeout");
`endif

    repeat (3) @(posedge CLK);
    #1;
    chk("sb_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
